// File: rtl/parity_frame_checker.sv
// Frame-level parity checker for the XNOR/parity stage: FRAME_LEN data samples plus one check sample per frame.
// Optional error counter output enabled by defining PARITY_FRAME_ERR_COUNT_EN.
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             d_in,
    input  logic             e_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_ok,
    output logic [CNT_W-1:0] match_cnt
`ifdef PARITY_FRAME_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {COLLECT, CHECK, RESULT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] match_reg, match_next;
    logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
    logic             acc_reg, acc_next;
    logic             out_valid_reg, out_valid_next;
    logic             par_ok_reg, par_ok_next;
    logic             xfer;

    assign in_ready  = (state_reg != RESULT);
    assign xfer      = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign par_ok    = par_ok_reg;
    assign match_cnt = match_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= COLLECT;
            count_reg     <= '0;
            match_reg     <= '0;
            match_cnt_reg <= '0;
            acc_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            par_ok_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            match_reg     <= match_next;
            match_cnt_reg <= match_cnt_next;
            acc_reg       <= acc_next;
            out_valid_reg <= out_valid_next;
            par_ok_reg    <= par_ok_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        match_next     = match_reg;
        match_cnt_next = match_cnt_reg;
        acc_next       = acc_reg;
        out_valid_next = out_valid_reg;
        par_ok_next    = par_ok_reg;
        case (state_reg)
            COLLECT: begin
                if (xfer) begin
                    acc_next = acc_reg ^ e_in;
                    if (d_in && (match_reg != CNT_MAX)) begin
                        match_next = match_reg + CNT_ONE;
                    end
                    if (count_reg == LAST) begin
                        count_next = '0;
                        state_next = CHECK;
                    end else begin
                        count_next = count_reg + CNT_ONE;
                    end
                end
            end
            CHECK: begin
                // d_in of the check sample carries no data and is deliberately dropped.
                if (xfer) begin
                    par_ok_next    = ~(acc_reg ^ e_in);
                    match_cnt_next = match_reg;
                    out_valid_next = 1'b1;
                    acc_next       = 1'b0;
                    match_next     = '0;
                    state_next     = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

`ifdef PARITY_FRAME_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

    assign err_cnt = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    // A failing frame is one whose running parity differs from its check sample.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if ((state_reg == CHECK) && xfer && (acc_reg ^ e_in) && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + CNT_ONE;
        end
    end
`endif

endmodule
